// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and baud-rate derivation.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

  // The transmitter on this link uses the same state encoding.
  typedef enum logic [1:0] {
    Idle     = 2'b00,
    StartBit = 2'b01,
    DataBit  = 2'b10,
    StopBit  = 2'b11
  } uart_state_t;

  // Clock cycles per bit, truncated.
  function automatic logic [31:0] calc_divider(input logic [31:0] frequency,
                                               input logic [31:0] speed);
    return frequency / speed;
  endfunction

  // Cycles from the start edge to the middle of the start bit.
  function automatic logic [31:0] calc_half(input logic [31:0] divider);
    return divider >> 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 CLK_i cycles from d to q.
// Backpressure: none; q simply follows d.
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK_i,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both come out of reset at the line's idle level.
  always_ff @(posedge CLK_i) begin
    if (reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling; good bytes pulse dataValid, bad stop bits pulse frameError.
// Latency: output pulse in the cycle after the stop-bit sample (start edge + 3 + HALF + 9*DIVIDER edges).
// Backpressure: none; the consumer must take data on the dataValid pulse.
module uart_receiver
  import uart_pkg::*;
#(
  parameter logic [31:0] FREQUENCY = 32'd50_000_000,
  parameter logic [31:0] SPEED     = 32'd1_500_000
) (
  input  logic       CLK_i,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       dataValid,
  output logic       frameError,
  output logic       busy
);

  localparam logic [31:0] DIVIDER = calc_divider(FREQUENCY, SPEED);
  localparam logic [31:0] HALF    = calc_half(DIVIDER);

  // With fewer than four cycles per bit the midpoint sample has no margin.
  if (DIVIDER < 32'd4) begin : g_divider_check
    $error("uart_receiver: FREQUENCY/SPEED must be at least 4");
  end

  uart_state_t state, state_nxt;
  logic        rx_s;
  logic        rx_d;
  logic        start_q;
  logic [31:0] tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        tick_done;
  logic        shift_en;
  logic        dv_nxt;
  logic        fe_nxt;

  bit_synchronizer #(.RESET_VAL(1'b1)) u_rx_sync (
    .CLK_i   (CLK_i),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // Edge detector: the falling edge is registered into a one-cycle start flag,
  // so StartBit is entered three edges after rx first lands in the synchronizer.
  // A line that stays low produces no further flags.
  always_ff @(posedge CLK_i) begin
    if (reset_n) begin
      rx_d    <= 1'b1;
      start_q <= 1'b0;
    end else begin
      rx_d    <= rx_s;
      start_q <= rx_d & ~rx_s;
    end
  end

  // State register.
  always_ff @(posedge CLK_i) begin
    if (reset_n) state <= Idle;
    else         state <= state_nxt;
  end

  // Next-state and sample strobes; start flags outside Idle are ignored.
  always_comb begin
    state_nxt = state;
    tick_done = 1'b0;
    shift_en  = 1'b0;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    case (state)
      Idle: begin
        if (start_q) state_nxt = StartBit;
      end
      StartBit: begin
        if (tick_cnt == HALF - 32'd1) begin
          tick_done = 1'b1;
          // Line back high at mid start bit: treat as a glitch.
          state_nxt = rx_s ? Idle : DataBit;
        end
      end
      DataBit: begin
        if (tick_cnt == DIVIDER - 32'd1) begin
          tick_done = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = StopBit;
        end
      end
      StopBit: begin
        if (tick_cnt == DIVIDER - 32'd1) begin
          tick_done = 1'b1;
          state_nxt = Idle;
          if (rx_s) dv_nxt = 1'b1;
          else      fe_nxt = 1'b1;
        end
      end
      default: state_nxt = Idle;
    endcase
  end

  // Tick and bit counters plus shift register; the tick counter restarts on
  // every state entry and at each data-bit boundary, and rests at zero in Idle.
  always_ff @(posedge CLK_i) begin
    if (reset_n) begin
      tick_cnt <= 32'd0;
      bit_cnt  <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      if (tick_done || (state_nxt != state) || (state == Idle)) tick_cnt <= 32'd0;
      else                                                     tick_cnt <= tick_cnt + 32'd1;
      if ((state == StartBit) && (state_nxt == DataBit)) bit_cnt <= 3'd0;
      else if (shift_en)                                 bit_cnt <= bit_cnt + 3'd1;
      // LSB arrives first, so new bits enter at the top and move down.
      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
    end
  end

  // Output registers: data only moves on a good frame; the pulses last one cycle.
  always_ff @(posedge CLK_i) begin
    if (reset_n) begin
      data       <= 8'h00;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      if (dv_nxt) data <= shift_q;
      dataValid  <= dv_nxt;
      frameError <= fe_nxt;
    end
  end

  assign busy = (state != Idle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIVIDER = 16, HALF = 8.
// Expected pulses are queued as frames are driven and matched as the DUT emits them.
// All checking runs in the single stimulus process, once per falling clock edge.
module tb_uart_receiver;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       dataValid;
  logic       frameError;
  logic       busy;

  uart_receiver #(
    .FREQUENCY (32'd16),
    .SPEED     (32'd1)
  ) dut (
    .CLK_i      (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .dataValid  (dataValid),
    .frameError (frameError),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 good byte, 1 frame error, 2 either error or corrupted byte
  typedef struct {
    int         kind;
    logic [7:0] dat;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp;
  int         n_err;
  int         cyc;
  logic       prev_pulse;
  logic [7:0] last_good;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and check any pulse against the scoreboard.
  task automatic step();
    exp_t e;
    logic pulse;
    @(negedge clk);
    cyc++;
    pulse = dataValid | frameError;
    if (pulse) begin
      chk("pulse_exclusive", 32'(dataValid & frameError), 32'd0);
      chk("pulse_width", 32'(prev_pulse), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, dataValid, frameError}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.kind == 0) begin
          chk("data_valid", 32'(dataValid), 32'd1);
          chk("data", 32'(data), 32'(e.dat));
        end else if (e.kind == 1) begin
          chk("frame_error", 32'(frameError), 32'd1);
          chk("data_hold", 32'(data), 32'(e.dat));
        end else begin
          chk("tolerance_detect", 32'(frameError | (dataValid & (data != 8'h55))), 32'd1);
        end
        if (e.at >= 0) chk("pulse_cycle", 32'(cyc), 32'(e.at));
      end
    end
    prev_pulse = pulse;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // Drive one frame; pc is the bit period in hundredths of a clock cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pc, input int kind);
    exp_t       e;
    int         e0;
    int         dur;
    logic [9:0] bits;
    bits   = {stop, b, 1'b0};
    e0     = cyc + 1;
    e.kind = kind;
    e.dat  = (kind == 1) ? last_good : b;
    e.at   = (pc == 1600) ? e0 + 155 : -1;
    sb.push_back(e);
    if (kind == 0) last_good = b;
    for (int i = 0; i < 10; i++) begin
      rx  = bits[i];
      dur = ((i + 1) * pc + 50) / 100 - (i * pc + 50) / 100;
      repeat (dur) step();
    end
  endtask

  initial begin
    int         e0;
    int         cnt;
    int         first;
    int         w;
    logic [9:0] bits;

    n_cmp      = 0;
    n_err      = 0;
    cyc        = 0;
    prev_pulse = 1'b0;
    last_good  = 8'h00;
    reset_n    = 1'b1;
    rx         = 1'b1;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_dv", 32'(dataValid), 32'd0);
    chk("reset_fe", 32'(frameError), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    idle(10);

    // Single good frame.
    send_frame(8'hA5, 1'b1, 1600, 0);
    idle(20);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1600, 0);
    send_frame(8'hFF, 1'b1, 1600, 0);
    idle(20);

    // Three-cycle low glitch on an idle line.
    rx = 1'b0;
    e0 = cyc + 1;
    repeat (3) step();
    rx    = 1'b1;
    cnt   = 0;
    first = -1;
    repeat (24) begin
      step();
      if (busy) begin
        cnt++;
        if (first < 0) first = cyc;
      end
    end
    chk("glitch_busy_cycles", 32'(cnt), 32'd8);
    chk("glitch_busy_rise", 32'(first), 32'(e0 + 3));
    idle(10);

    // Bad stop bit, then the line stays low: no retrigger without a new edge.
    send_frame(8'h3C, 1'b0, 1600, 1);
    rx = 1'b0;
    repeat (100) step();
    chk("low_line_no_start", 32'(busy), 32'd0);
    idle(30);

    // Reset in the middle of data bit 4 of 8'h5A, line then left idle.
    bits = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      repeat (16) step();
    end
    rx = bits[5];
    repeat (8) step();
    reset_n = 1'b1;
    step();
    reset_n = 1'b0;
    chk("midframe_reset_busy", 32'(busy), 32'd0);
    chk("midframe_reset_data", 32'(data), 32'h00);
    last_good = 8'h00;
    idle(40);
    send_frame(8'h81, 1'b1, 1600, 0);
    idle(20);

    // Line 3% fast: still inside the tolerance window.
    send_frame(8'h55, 1'b1, 1552, 0);
    idle(40);

    // Line 8% fast, followed by a low level where the stop sample lands.
    send_frame(8'h55, 1'b1, 1472, 2);
    rx = 1'b0;
    repeat (30) step();
    idle(200);

    w = 0;
    while ((sb.size() != 0) && (w < 500)) begin
      step();
      w++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first, paired with the existing transmitter on the same link. It recovers bytes from the RxD line, sampling each bit at its midpoint. Each good byte is presented with a one-cycle valid pulse to the downstream decoder. Frames with a bad stop bit are flagged and discarded.

## Interface
- FREQUENCY, 32'd50_000_000, system clock frequency in Hz
- SPEED, 32'd1_500_000, baud rate in bit/s
- CLK_i  input  1  system clock, all logic on rising edge
- reset_n  input  1  reset, synchronous, active-high (asserted = 1), despite the suffix
- rx  input  1  serial line (UART RxD), asynchronous to CLK_i, idles high
- data  output  8  last correctly received byte; held until the next good frame
- dataValid  output  1  one-cycle pulse, data updated this cycle
- frameError  output  1  one-cycle pulse, stop bit sampled low, frame dropped
- busy  output  1  high while a frame is in progress (state ≠ Idle)

## Operation
- DIVIDER = FREQUENCY/SPEED (integer divide, 33 at defaults).
- HALF = DIVIDER/2.
- DIVIDER ≥ 4 is required; a simulation-time check fails elaboration otherwise.
- rx passes through a 2-FF synchronizer to produce rx_s. A third register rx_d holds the previous rx_s for edge detection.
- The tick counter is 32 bits and is cleared on every state entry.
- The bit counter is 3 bits. The shift register is 8 bits and shifts right, with the new bit entering at [7].
- Idle:
  - busy = 0.
  - On rx_d = 1 and rx_s = 0 (falling edge), go to StartBit.
  - A line held low never re-triggers; a high→low edge is required.
- StartBit:
  - When the counter reaches HALF-1, sample rx_s.
  - If rx_s = 1, it was a glitch: return to Idle with no pulse.
  - If rx_s = 0, go to DataBit with bit counter = 0.
- DataBit:
  - When the counter reaches DIVIDER-1, shift rx_s in and increment the bit counter.
  - After the 8th sample (bit counter wraps from 7), go to StopBit.
- StopBit:
  - When the counter reaches DIVIDER-1, sample rx_s.
  - If 1: data ← shift register and dataValid = 1.
  - If 0: frameError = 1 and data is unchanged.
  - Either way, go to Idle.
- dataValid and frameError are never both high. Neither is high for more than one cycle.
- There is no backpressure. The consumer must take data on dataValid; the next byte may overwrite it one frame later.
- A start edge arriving while not in Idle is ignored.
- Reset at any time, including mid-frame:
  - state = Idle and all counters = 0.
  - shift register = 0 and synchronizer flops = 1.
  - data = 8'h00, dataValid = 0, frameError = 0, busy = 0.
  - No pulse is emitted for the aborted frame.

## Timing
- Let clock edge E0 be the first edge at which the rx synchronizer input flop registers 0.
- StartBit is entered at E3.
- Start midpoint sample occurs at E3+HALF.
- Data bit k (k = 0..7) is sampled at E3+HALF+(k+1)·DIVIDER.
- The stop bit is sampled at E3+HALF+9·DIVIDER.
- dataValid or frameError is high during the cycle following the stop-sample edge.
- busy rises at E3 and falls with the dataValid/frameError pulse.
- After a good frame, Idle is re-entered immediately. A start edge arriving in that same cycle is caught, giving back-to-back frames with no gap.
- Baud tolerance is ±(HALF-1)/DIVIDER of one bit, accumulated over the 10-bit frame.

## Structure
- Package uart_pkg:
  - state encoding Idle/StartBit/DataBit/StopBit (2'b00..2'b11), shared with the transmitter
  - DIVIDER and HALF derivation as constant functions
- Sub-module bit_synchronizer:
  - 2-FF synchronizer with a reset value parameter (1 for rx)
  - reusable for other asynchronous inputs
- Top: FSM, tick/bit counters, shift register, output registers. Target about 150–200 lines.

## Test plan
All scenarios use FREQUENCY = 16, SPEED = 1, so DIVIDER = 16 and HALF = 8.
- Drive a frame of 8'hA5, stop = 1 → dataValid one pulse at E3+152, data = 8'hA5, frameError stays 0.
- Send 8'h00 then 8'hFF back-to-back, no idle gap → two dataValid pulses 160 cycles apart, data = 8'h00, then 8'hFF.
- Low glitch of 3 cycles on an idle line → return to Idle at E3+8, no dataValid, no frameError, busy high for 8 cycles only.
- Frame 8'h3C with stop bit = 0, line then held low for 100 cycles → one frameError pulse, data keeps its previous value, no new start until rx returns high and falls again.
- Assert reset_n for 1 cycle during data bit 4 of frame 8'h5A → busy = 0 the next cycle, no pulses. A following frame 8'h81 is received correctly.
- Line fast by 3% over a frame of 8'h55 → data = 8'h55 received without error. Line fast by 8% → frameError or wrong byte, demonstrating the tolerance bound.
